debug_loader: RTL and testbench

Host-side control unit for the pipelined MIPS datapath: the in-hardware counterpart of the simulation bench that currently clocks and resets the pipeline. It receives command and program bytes from the UART receiver and assembles them into words written to instruction memory. It then releases the datapath reset and gates the pipeline enable, either free-running until HALT or one cycle per step. Status bytes go back through the UART transmitter.

---
 rtl/debug_loader.sv | 200 ++++++++++++++++++++
 tb/tb_debug_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_loader.sv
// debug_loader: host-side control for the pipelined MIPS datapath.
// Receives commands and program bytes over the UART and writes little-endian
// words into instruction memory. Controls the datapath reset and the pipeline
// enable (free-run or single step), and reports status bytes back over the UART.
module debug_loader #(
   parameter int NBITS    = 32,
   parameter int MEM_SIZE = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          i_rx_data,
   input  logic                i_rx_valid,
   input  logic                i_halt,
   input  logic                i_tx_busy,
   output logic                o_imem_we,
   output logic [MEM_SIZE-1:0] o_imem_addr,
   output logic [NBITS-1:0]    o_imem_data,
   output logic                o_pipe_rst,
   output logic                o_pipe_en,
   output logic [7:0]          o_tx_data,
   output logic                o_tx_start,
   output logic [2:0]          o_state
);

   localparam int BYTES = NBITS / 8;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int WCW   = (MEM_SIZE + 1 > 8) ? MEM_SIZE + 1 : 8;

   localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BYTES - 1);
   localparam logic [MEM_SIZE-1:0] LAST_ADDR = '1;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_CONT = 8'h43;
   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] RSP_HALT = 8'h48;
   localparam logic [7:0] RSP_STEP = 8'h53;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RUN  = 3'd2,
      STEP = 3'd3,
      TX   = 3'd4
   } state_t;

   state_t              state, state_n;
   logic                imem_we_n;
   logic [MEM_SIZE-1:0] imem_addr_n;
   logic [NBITS-1:0]    imem_data_n;
   logic                pipe_rst_n;
   logic                pipe_en_n;
   logic [7:0]          tx_data_n;
   logic                tx_start_n;
   logic [BCW-1:0]      byte_cnt, byte_cnt_n;
   logic [WCW-1:0]      word_cnt, word_cnt_n;
   logic                halted, halted_n;
   logic [NBITS-1:0]    asm_word, asm_word_n;

   assign o_state = state;

   // Register every output and all internal state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         o_imem_we   <= 1'b0;
         o_imem_addr <= '0;
         o_imem_data <= '0;
         o_pipe_rst  <= 1'b1;
         o_pipe_en   <= 1'b0;
         o_tx_data   <= '0;
         o_tx_start  <= 1'b0;
         byte_cnt    <= '0;
         word_cnt    <= '0;
         halted      <= 1'b0;
         asm_word    <= '0;
      end else begin
         state       <= state_n;
         o_imem_we   <= imem_we_n;
         o_imem_addr <= imem_addr_n;
         o_imem_data <= imem_data_n;
         o_pipe_rst  <= pipe_rst_n;
         o_pipe_en   <= pipe_en_n;
         o_tx_data   <= tx_data_n;
         o_tx_start  <= tx_start_n;
         byte_cnt    <= byte_cnt_n;
         word_cnt    <= word_cnt_n;
         halted      <= halted_n;
         asm_word    <= asm_word_n;
      end
   end

   // Next-state and next-output decode for command, load, run/step and reply.
   always_comb begin
      state_n     = state;
      imem_we_n   = 1'b0;
      imem_addr_n = o_imem_addr;
      imem_data_n = o_imem_data;
      pipe_rst_n  = o_pipe_rst;
      pipe_en_n   = 1'b0;
      tx_data_n   = o_tx_data;
      tx_start_n  = 1'b0;
      byte_cnt_n  = byte_cnt;
      word_cnt_n  = word_cnt;
      halted_n    = halted;
      asm_word_n  = asm_word;

      case (state)
         IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_LOAD: begin
                     state_n     = LOAD;
                     imem_addr_n = '0;
                     word_cnt_n  = '0;
                     byte_cnt_n  = '0;
                     halted_n    = 1'b0;
                     pipe_rst_n  = 1'b1;
                     asm_word_n  = '0;
                  end
                  CMD_CONT: begin
                     if (halted) begin
                        state_n   = TX;
                        tx_data_n = RSP_HALT;
                     end else begin
                        state_n   = RUN;
                        pipe_en_n = 1'b1;
                     end
                  end
                  CMD_STEP: begin
                     if (halted) begin
                        state_n   = TX;
                        tx_data_n = RSP_HALT;
                     end else begin
                        state_n   = STEP;
                        pipe_en_n = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end

         LOAD: begin
            // The write cycle advances the address; a byte arriving in that same
            // cycle (back-to-back strobes) already sees the advanced address.
            if (o_imem_we) begin
               imem_addr_n = o_imem_addr + 1'b1;
               word_cnt_n  = word_cnt + 1'b1;
               if ((o_imem_data == '1) || (o_imem_addr == LAST_ADDR)) begin
                  pipe_rst_n = 1'b0;
                  state_n    = TX;
                  tx_data_n  = word_cnt_n[7:0];
               end
            end
            if (i_rx_valid && (state_n == LOAD)) begin
               // Shift in from the top so the first byte ends up in bits 7:0.
               asm_word_n                = asm_word >> 8;
               asm_word_n[NBITS-1 -: 8]  = i_rx_data;
               if (byte_cnt == LAST_BYTE) begin
                  imem_we_n   = 1'b1;
                  imem_data_n = asm_word_n;
                  byte_cnt_n  = '0;
               end else begin
                  byte_cnt_n = byte_cnt + 1'b1;
               end
            end
         end

         RUN: begin
            if (i_halt) begin
               halted_n  = 1'b1;
               state_n   = TX;
               tx_data_n = RSP_HALT;
            end else begin
               pipe_en_n = 1'b1;
            end
         end

         STEP: begin
            state_n = TX;
            if (i_halt) begin
               halted_n  = 1'b1;
               tx_data_n = RSP_HALT;
            end else begin
               tx_data_n = RSP_STEP;
            end
         end

         TX: begin
            if (!i_tx_busy) begin
               tx_start_n = 1'b1;
               state_n    = IDLE;
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_debug_loader.sv
// tb_debug_loader: randomized scoreboard bench for debug_loader.
module tb_debug_loader;

   localparam int NBITS    = 32;
   localparam int MEM_SIZE = 7;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [7:0]          rx_data = '0;
   logic                rx_valid = 1'b0;
   logic                halt = 1'b0;
   logic                tx_busy = 1'b0;
   logic                imem_we;
   logic [MEM_SIZE-1:0] imem_addr;
   logic [NBITS-1:0]    imem_data;
   logic                pipe_rst;
   logic                pipe_en;
   logic [7:0]          tx_data;
   logic                tx_start;
   logic [2:0]          state;

   debug_loader #(.NBITS(NBITS), .MEM_SIZE(MEM_SIZE)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rx_data   (rx_data),
      .i_rx_valid  (rx_valid),
      .i_halt      (halt),
      .i_tx_busy   (tx_busy),
      .o_imem_we   (imem_we),
      .o_imem_addr (imem_addr),
      .o_imem_data (imem_data),
      .o_pipe_rst  (pipe_rst),
      .o_pipe_en   (pipe_en),
      .o_tx_data   (tx_data),
      .o_tx_start  (tx_start),
      .o_state     (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [MEM_SIZE-1:0] addr;
      logic [NBITS-1:0]    data;
   } wr_t;

   typedef struct {
      logic [7:0]  b;
      int unsigned en;
   } tx_t;

   wr_t         wr_q[$];
   tx_t         tx_q[$];
   logic [31:0] words[$];
   int          compared   = 0;
   int          mismatched = 0;
   int unsigned tx_seen    = 0;
   int unsigned tx_expect  = 0;
   int unsigned en_cnt     = 0;
   logic        prev_start = 1'b0;
   bit          model_halted = 1'b0;
   wr_t         mw;
   tx_t         mt;

   task automatic check(input string name, input longint unsigned act,
                        input longint unsigned exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes memory or starts a reply.
   always @(negedge clk) begin
      if (!rst) begin
         en_cnt     = 0;
         prev_start = 1'b0;
      end else begin
         if (imem_we) begin
            if (wr_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want none",
                        imem_addr, imem_data);
            end else begin
               mw = wr_q.pop_front();
               check("wr_addr", imem_addr, mw.addr);
               check("wr_data", imem_data, mw.data);
               check("wr_pipe_rst", pipe_rst, 1);
               check("wr_state", state, 1);
            end
         end
         if (tx_start) begin
            if (tx_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_tx: got byte 0x%0h, want none", tx_data);
            end else begin
               mt = tx_q.pop_front();
               check("tx_byte", tx_data, mt.b);
               check("tx_enable_cycles", en_cnt, mt.en);
               check("tx_pipe_rst", pipe_rst, 0);
            end
            check("tx_start_single", prev_start, 0);
            tx_seen++;
            en_cnt = 0;
         end
         if (pipe_en) en_cnt++;
         prev_start = tx_start;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++)
         send_byte(w[8*i +: 8], $urandom_range(0, 2));
   endtask

   task automatic wait_tx(input int unsigned target);
      int unsigned budget = 0;
      while (tx_seen < target && budget < 3000) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check("tx_response_arrived", tx_seen, target);
   endtask

   task automatic push_tx(input logic [7:0] b, input int unsigned en);
      tx_t t;
      t.b  = b;
      t.en = en;
      tx_q.push_back(t);
      tx_expect++;
   endtask

   // Loads the words queue; load stops at the first all-ones word or 128 words.
   task automatic do_load(input bit busy_end);
      wr_t         w;
      int unsigned n = 0;
      int unsigned seen;
      send_byte(8'h4C, $urandom_range(0, 2));
      model_halted = 1'b0;
      foreach (words[i]) begin
         w.addr = MEM_SIZE'(i);
         w.data = words[i];
         wr_q.push_back(w);
         n++;
         if (words[i] == 32'hFFFF_FFFF || n == 128) begin
            push_tx(8'(n), 0);
            if (busy_end) tx_busy = 1'b1;
            send_word(words[i]);
            break;
         end
         send_word(words[i]);
      end
      if (busy_end) begin
         seen = tx_seen;
         repeat (20) begin
            @(posedge clk);
            #1;
         end
         check("tx_held_while_busy", tx_seen, seen);
         tx_busy = 1'b0;
      end
      wait_tx(tx_expect);
   endtask

   task automatic random_words(input int unsigned n, input bit end_halt);
      logic [31:0] w;
      words.delete();
      for (int unsigned i = 0; i < n; i++) begin
         w = $urandom;
         if (w == 32'hFFFF_FFFF) w = '0;
         if (end_halt && i == n - 1) w = 32'hFFFF_FFFF;
         words.push_back(w);
      end
   endtask

   // n = enable cycles from the command to the cycle halt is first sampled.
   task automatic do_run(input int unsigned n);
      if (model_halted) begin
         push_tx(8'h48, 0);
         send_byte(8'h43, 0);
      end else begin
         push_tx(8'h48, n);
         send_byte(8'h43, 0);
         for (int unsigned i = 1; i < n; i++) begin
            @(posedge clk);
            #1;
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
         end
         rx_valid     = 1'b0;
         halt         = 1'b1;
         model_halted = 1'b1;
      end
      wait_tx(tx_expect);
      halt = 1'b0;
   endtask

   task automatic do_step(input bit h);
      if (model_halted) begin
         push_tx(8'h48, 0);
      end else if (h) begin
         push_tx(8'h48, 1);
         model_halted = 1'b1;
      end else begin
         push_tx(8'h53, 1);
      end
      halt = h;
      send_byte(8'h53, 0);
      wait_tx(tx_expect);
      halt = 1'b0;
   endtask

   task automatic send_junk();
      logic [7:0] b;
      do b = 8'($urandom); while (b == 8'h4C || b == 8'h43 || b == 8'h53);
      send_byte(b, 1);
      check("idle_after_junk", state, 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_imem_we"}, imem_we, 0);
      check({tag, "_imem_addr"}, imem_addr, 0);
      check({tag, "_imem_data"}, imem_data, 0);
      check({tag, "_pipe_rst"}, pipe_rst, 1);
      check({tag, "_pipe_en"}, pipe_en, 0);
      check({tag, "_tx_data"}, tx_data, 0);
      check({tag, "_tx_start"}, tx_start, 0);
      check({tag, "_state"}, state, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_reset("por");
      rst = 1'b1;
      @(posedge clk);
      #1;

      repeat (3) send_junk();

      // Directed program: two addi words then HALT.
      words.delete();
      words.push_back(32'h2001_0005);
      words.push_back(32'h2002_0003);
      words.push_back(32'hFFFF_FFFF);
      do_load(1'b0);
      do_run(10);
      do_run(10);

      // Fresh load, then single steps.
      random_words(3, 1'b1);
      do_load(1'b0);
      repeat (3) do_step(1'b0);
      do_step(1'b1);
      do_step(1'b0);

      // Random program and a random-length run.
      random_words($urandom_range(2, 8), 1'b1);
      do_load(1'b0);
      do_run($urandom_range(1, 20));
      send_junk();

      // Full memory without HALT, transmitter busy at the end.
      random_words(128, 1'b0);
      do_load(1'b1);

      // Reset in the middle of a word.
      send_byte(8'h4C, 1);
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      rst = 1'b0;
      #1;
      check_reset("mid_load_rst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_halted = 1'b0;
      random_words(1, 1'b0);
      words.push_back(32'hFFFF_FFFF);
      do_load(1'b0);

      repeat (4) @(posedge clk);
      #1;
      check("write_queue_drained", wr_q.size(), 0);
      check("tx_queue_drained", tx_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
